// File: rtl/conway_window_feeder.sv
`default_nettype none
// ============================================================================
// Module      : conway_window_feeder
// Description : Producer side of the Conway row-window interface. Walks a
//               ROWS x WORDS_PER_ROW grid of WORD_LEN-bit words held in a
//               single-port read memory, in raster order. For each word it
//               builds the three halo-padded (WORD_LEN+2)-bit row slices
//               (top/middle/bottom) and offers them over valid/ready.
//               Cells outside the grid read as dead; the grid is not toroidal.
// Ports       : clk, reset_n          clock / asynchronous active-low reset
//               start, busy           frame start (sampled in IDLE) / frame busy
//               rd_en, rd_addr        memory read strobe / word address
//               rd_data               read data, one cycle after rd_en
//               win_valid, win_ready  window handshake
//               top_row, middle_row,
//               bottom_row            halo-padded slices of rows r-1, r, r+1
//               win_row, win_col      grid position of the current window
//               frame_done            one-cycle pulse after the last window
// Revision    : 1.0 - initial release
// ============================================================================
module conway_window_feeder #(
    parameter int WORD_LEN      = 20,
    parameter int ROWS          = 8,
    parameter int WORDS_PER_ROW = 4,
    parameter int ADDR_W        = $clog2(ROWS * WORDS_PER_ROW),
    // Derived index widths; leave at their defaults.
    parameter int ROW_W         = (ROWS > 1) ? $clog2(ROWS) : 1,
    parameter int COL_W         = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  rd_en,
    output logic [ADDR_W-1:0]     rd_addr,
    input  logic [WORD_LEN-1:0]   rd_data,
    output logic                  win_valid,
    input  logic                  win_ready,
    output logic [WORD_LEN+1:0]   top_row,
    output logic [WORD_LEN+1:0]   middle_row,
    output logic [WORD_LEN+1:0]   bottom_row,
    output logic [ROW_W-1:0]      win_row,
    output logic [COL_W-1:0]      win_col,
    output logic                  frame_done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PRIME = 3'd1,
        S_FETCH = 3'd2,
        S_EMIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [1:0]            r_phase;      // cycle within a 4-cycle column fetch
    logic [ROW_W-1:0]      r_row;
    logic [COL_W-1:0]      r_col;
    logic                  r_slot_vld;   // a real read was issued last cycle
    logic [WORD_LEN-1:0]   r_f0;         // fetched word for row r-1
    logic [WORD_LEN-1:0]   r_f1;         // fetched word for row r

    // Per window row (0=top,1=middle,2=bottom). Only the MSB of the previous
    // word contributes to the slice, so only that bit is kept.
    logic                  r_prev [3];
    logic [WORD_LEN-1:0]   r_cur  [3];
    logic [WORD_LEN-1:0]   r_next [3];

    logic                  w_fetching;
    logic                  w_slot_ok;
    logic [WORD_LEN-1:0]   w_cap;
    logic [WORD_LEN-1:0]   w_fetched [3];
    logic                  w_accept;
    logic                  w_last_col;
    logic                  w_last_row;
    logic                  w_row_start;
    int                    w_frow;
    int                    w_fcol;

    assign w_fetching = (r_state == S_PRIME) || (r_state == S_FETCH);
    assign w_accept   = (r_state == S_EMIT) && win_ready;
    assign w_last_col = (r_col == COL_W'(WORDS_PER_ROW - 1));
    assign w_last_row = (r_row == ROW_W'(ROWS - 1));
    // The window is cleared whenever a new row begins its PRIME fetch.
    assign w_row_start = ((r_state == S_IDLE) && start) ||
                         (w_accept && w_last_col && !w_last_row);

    // Read slot: phases 0..2 address rows r-1, r, r+1 of the fetch column.
    // PRIME always fetches column 0; FETCH fetches one column ahead of w.
    always_comb begin
        w_fcol    = (r_state == S_PRIME) ? 0 : int'(r_col) + 1;
        w_frow    = int'(r_row) - 1 + int'(r_phase);
        w_slot_ok = w_fetching && (r_phase != 2'd3) &&
                    (w_frow >= 0) && (w_frow < ROWS) &&
                    (w_fcol < WORDS_PER_ROW);
        rd_en     = w_slot_ok;
        rd_addr   = w_slot_ok ? ADDR_W'(w_frow * WORDS_PER_ROW + w_fcol)
                              : {ADDR_W{1'b0}};
    end

    // Data returning for a slot that never issued a read is forced dead.
    assign w_cap = r_slot_vld ? rd_data : {WORD_LEN{1'b0}};

    always_comb begin
        w_fetched[0] = r_f0;
        w_fetched[1] = r_f1;
        w_fetched[2] = w_cap;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_PRIME;
            S_PRIME: if (r_phase == 2'd3) w_state_nxt = S_FETCH;
            S_FETCH: if (r_phase == 2'd3) w_state_nxt = S_EMIT;
            S_EMIT: begin
                if (win_ready) begin
                    if (!w_last_col)      w_state_nxt = S_FETCH;
                    else if (!w_last_row) w_state_nxt = S_PRIME;
                    else                  w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_phase    <= 2'd0;
            r_row      <= {ROW_W{1'b0}};
            r_col      <= {COL_W{1'b0}};
            r_slot_vld <= 1'b0;
            r_f0       <= {WORD_LEN{1'b0}};
            r_f1       <= {WORD_LEN{1'b0}};
            for (int k = 0; k < 3; k++) begin
                r_prev[k] <= 1'b0;
                r_cur[k]  <= {WORD_LEN{1'b0}};
                r_next[k] <= {WORD_LEN{1'b0}};
            end
        end else begin
            r_slot_vld <= w_slot_ok;
            r_phase    <= w_fetching ? r_phase + 2'd1 : 2'd0;

            if (w_fetching) begin
                case (r_phase)
                    2'd1: r_f0 <= w_cap;
                    2'd2: r_f1 <= w_cap;
                    2'd3: begin
                        for (int k = 0; k < 3; k++) begin
                            r_prev[k] <= r_cur[k][WORD_LEN-1];
                            r_cur[k]  <= r_next[k];
                            r_next[k] <= w_fetched[k];
                        end
                    end
                    default: ;
                endcase
            end

            if (w_row_start) begin
                for (int k = 0; k < 3; k++) begin
                    r_prev[k] <= 1'b0;
                    r_cur[k]  <= {WORD_LEN{1'b0}};
                    r_next[k] <= {WORD_LEN{1'b0}};
                end
            end

            if ((r_state == S_IDLE) && start) begin
                r_row <= {ROW_W{1'b0}};
                r_col <= {COL_W{1'b0}};
            end

            if (w_accept) begin
                if (!w_last_col) begin
                    r_col <= r_col + COL_W'(1);
                end else begin
                    r_col <= {COL_W{1'b0}};
                    if (!w_last_row) r_row <= r_row + ROW_W'(1);
                end
            end
        end
    end

    assign busy       = (r_state == S_PRIME) || (r_state == S_FETCH) ||
                        (r_state == S_EMIT);
    assign win_valid  = (r_state == S_EMIT);
    assign frame_done = (r_state == S_DONE);
    assign win_row    = r_row;
    assign win_col    = r_col;
    assign top_row    = {r_next[0][0], r_cur[0], r_prev[0]};
    assign middle_row = {r_next[1][0], r_cur[1], r_prev[1]};
    assign bottom_row = {r_next[2][0], r_cur[2], r_prev[2]};

endmodule
`default_nettype wire

// File: tb/tb_conway_window_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_conway_window_feeder
// Description : Directed self-checking bench for conway_window_feeder on a
//               3 x 2 grid of 20-bit words, with a one-cycle-latency memory.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_conway_window_feeder;

    localparam int WL = 20;
    localparam int NR = 3;
    localparam int NC = 2;
    localparam int AW = 3;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            start;
    logic            busy;
    logic            rd_en;
    logic [AW-1:0]   rd_addr;
    logic [WL-1:0]   rd_data;
    logic            win_valid;
    logic            win_ready;
    logic [WL+1:0]   top_row;
    logic [WL+1:0]   middle_row;
    logic [WL+1:0]   bottom_row;
    logic [1:0]      win_row;
    logic [0:0]      win_col;
    logic            frame_done;

    conway_window_feeder #(
        .WORD_LEN(WL), .ROWS(NR), .WORDS_PER_ROW(NC)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .busy(busy),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .win_valid(win_valid), .win_ready(win_ready),
        .top_row(top_row), .middle_row(middle_row), .bottom_row(bottom_row),
        .win_row(win_row), .win_col(win_col), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Memory: data one cycle after rd_en; junk when no read was issued.
    logic [WL-1:0] mem [6];
    always @(posedge clk) rd_data <= rd_en ? mem[rd_addr] : 20'hABCDE;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          r;
        int          c;
        logic [21:0] t;
        logic [21:0] m;
        logic [21:0] b;
        int          cy;
    } win_t;

    win_t wq[$];
    int   n_rd = 0;
    int   n_bad = 0;
    int   n_fd = 0;
    int   t0 = 0;
    int   vectors = 0;
    int   miscompares = 0;

    // Monitor: accepted windows, read strobes and frame_done pulses.
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            if (win_valid && win_ready)
                wq.push_back('{int'(win_row), int'(win_col), top_row,
                               middle_row, bottom_row, cyc - t0});
            if (rd_en) begin
                n_rd++;
                if (rd_addr >= 3'd6) n_bad++;
            end
            if (frame_done) n_fd++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame();
        start = 1'b1;
        t0    = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        int base;
        base = n_fd;
        ok   = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (n_fd != base) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic load_halo();
        for (int i = 0; i < 6; i++) mem[i] = '0;
        mem[2] = 20'h80001;
    endtask

    task automatic test_reset();
        logic [AW+3*22+6:0] outs;
        reset_n   = 1'b0;
        start     = 1'b1;
        win_ready = 1'b1;
        load_halo();
        repeat (3) tick();
        outs = {busy, rd_en, rd_addr, win_valid, top_row, middle_row,
                bottom_row, win_row, win_col, frame_done};
        vectors++;
        if (outs !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h expected 0", outs);
        end
        start = 1'b0;
        tick();
        reset_n = 1'b1;
        repeat (5) tick();
        vectors++;
        if ({busy, rd_en, win_valid} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_idle: busy/rd_en/valid got %b expected 000",
                     {busy, rd_en, win_valid});
        end
        start_frame();
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL start_busy: got %b expected 1", busy);
        end
        begin
            bit ok;
            wait_done(300, ok);
            vectors++;
            if (!ok) begin
                miscompares++;
                $display("FAIL reset_frame_timeout: got no frame_done expected one");
            end
        end
    endtask

    task automatic test_halo_count();
        logic [21:0] et [6];
        logic [21:0] em [6];
        logic [21:0] eb [6];
        int  base, rd0, bad0, fd0;
        bit  ok;
        et = '{22'h0, 22'h0, 22'h0, 22'h0, 22'h100002, 22'h000001};
        em = '{22'h0, 22'h0, 22'h100002, 22'h000001, 22'h0, 22'h0};
        eb = '{22'h100002, 22'h000001, 22'h0, 22'h0, 22'h0, 22'h0};
        load_halo();
        win_ready = 1'b1;
        base = wq.size(); rd0 = n_rd; bad0 = n_bad; fd0 = n_fd;
        start_frame();
        wait_done(300, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL halo_timeout: got no frame_done expected one");
        end
        repeat (3) tick();
        vectors++;
        if (wq.size() - base !== 6) begin
            miscompares++;
            $display("FAIL halo_count: got %0d windows expected 6", wq.size() - base);
        end
        for (int i = 0; i < 6; i++) begin
            vectors++;
            if (base + i >= wq.size()) begin
                miscompares++;
                $display("FAIL halo_win%0d: got missing window expected present", i);
            end else if (wq[base+i].r !== i / 2 || wq[base+i].c !== i % 2 ||
                         wq[base+i].t !== et[i] || wq[base+i].m !== em[i] ||
                         wq[base+i].b !== eb[i]) begin
                miscompares++;
                $display("FAIL halo_win%0d: got (%0d,%0d) %h/%h/%h expected (%0d,%0d) %h/%h/%h",
                         i, wq[base+i].r, wq[base+i].c, wq[base+i].t, wq[base+i].m,
                         wq[base+i].b, i / 2, i % 2, et[i], em[i], eb[i]);
            end
        end
        vectors++;
        if (n_rd - rd0 !== 14) begin
            miscompares++;
            $display("FAIL rd_en_count: got %0d expected 14", n_rd - rd0);
        end
        vectors++;
        if (n_bad - bad0 !== 0) begin
            miscompares++;
            $display("FAIL rd_addr_range: got %0d out-of-range expected 0", n_bad - bad0);
        end
        vectors++;
        if (n_fd - fd0 !== 1) begin
            miscompares++;
            $display("FAIL frame_done_count: got %0d expected 1", n_fd - fd0);
        end
    endtask

    task automatic test_timing();
        int base;
        bit ok;
        int exp_cy [3];
        exp_cy = '{9, 14, 23};
        load_halo();
        win_ready = 1'b1;
        base = wq.size();
        start_frame();
        wait_done(300, ok);
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (base + i >= wq.size()) begin
                miscompares++;
                $display("FAIL timing_win%0d: got missing expected cycle %0d", i, exp_cy[i]);
            end else if (wq[base+i].cy !== exp_cy[i]) begin
                miscompares++;
                $display("FAIL timing_win%0d: got cycle %0d expected %0d",
                         i, wq[base+i].cy, exp_cy[i]);
            end
        end
    endtask

    task automatic test_edges();
        logic [21:0] et [6];
        logic [21:0] em [6];
        logic [21:0] eb [6];
        int  base;
        bit  ok;
        for (int i = 0; i < 6; i++) mem[i] = '0;
        mem[1] = 20'h00001;
        mem[4] = 20'h80000;
        et = '{22'h0, 22'h0, 22'h200000, 22'h000002, 22'h0, 22'h0};
        em = '{22'h200000, 22'h000002, 22'h0, 22'h0, 22'h100000, 22'h000001};
        eb = '{22'h0, 22'h0, 22'h100000, 22'h000001, 22'h0, 22'h0};
        win_ready = 1'b1;
        base = wq.size();
        start_frame();
        wait_done(300, ok);
        for (int i = 0; i < 6; i++) begin
            vectors++;
            if (base + i >= wq.size()) begin
                miscompares++;
                $display("FAIL edge_win%0d: got missing window expected present", i);
            end else if (wq[base+i].t !== et[i] || wq[base+i].m !== em[i] ||
                         wq[base+i].b !== eb[i]) begin
                miscompares++;
                $display("FAIL edge_win%0d: got %h/%h/%h expected %h/%h/%h", i,
                         wq[base+i].t, wq[base+i].m, wq[base+i].b, et[i], em[i], eb[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [68:0] snap;
        int  base;
        bit  ok, found;
        load_halo();
        win_ready = 1'b1;
        base  = wq.size();
        found = 1'b0;
        start_frame();
        for (int i = 0; i < 200; i++) begin
            if (win_valid && win_row == 2'd1 && win_col == 1'b0) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        win_ready = 1'b0;
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL bp_reach: got no (1,0) window expected one");
        end
        snap = {top_row, middle_row, bottom_row, win_row, win_col};
        for (int i = 0; i < 10; i++) begin
            tick();
            vectors++;
            if ({top_row, middle_row, bottom_row, win_row, win_col} !== snap ||
                rd_en !== 1'b0 || win_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL bp_hold%0d: got %h rd_en=%b valid=%b expected %h rd_en=0 valid=1",
                         i, {top_row, middle_row, bottom_row, win_row, win_col},
                         rd_en, win_valid, snap);
            end
        end
        win_ready = 1'b1;
        wait_done(300, ok);
        vectors++;
        if (!ok || wq.size() - base !== 6) begin
            miscompares++;
            $display("FAIL bp_complete: got %0d windows expected 6", wq.size() - base);
        end
        vectors++;
        if (base + 2 >= wq.size() || wq[base+2].m !== 22'h100002 ||
            wq[base+2].r !== 1 || wq[base+2].c !== 0) begin
            miscompares++;
            $display("FAIL bp_data: got window 2 wrong expected (1,0) middle 100002");
        end
    endtask

    task automatic test_abuse();
        int  base, fd0;
        bit  ok;
        logic [AW+3*22+6:0] outs;
        load_halo();
        win_ready = 1'b1;
        base = wq.size();
        fd0  = n_fd;
        start_frame();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (8) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(300, ok);
        repeat (6) tick();
        vectors++;
        if (wq.size() - base !== 6 || n_fd - fd0 !== 1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL start_while_busy: got %0d windows %0d done busy=%b expected 6 1 0",
                     wq.size() - base, n_fd - fd0, busy);
        end
        // Abort a frame in the middle of its first FETCH.
        start_frame();
        repeat (5) tick();
        vectors++;
        if (rd_en !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_setup: got rd_en=%b expected 1", rd_en);
        end
        reset_n = 1'b0;
        @(negedge clk);
        outs = {busy, rd_en, rd_addr, win_valid, top_row, middle_row,
                bottom_row, win_row, win_col, frame_done};
        vectors++;
        if (outs !== '0) begin
            miscompares++;
            $display("FAIL abort_outputs: got %h expected 0", outs);
        end
        tick();
        reset_n = 1'b1;
        tick();
        base = wq.size();
        start_frame();
        wait_done(300, ok);
        vectors++;
        if (!ok || wq.size() - base !== 6) begin
            miscompares++;
            $display("FAIL restart_count: got %0d windows expected 6", wq.size() - base);
        end
        vectors++;
        if (base >= wq.size() || wq[base].r !== 0 || wq[base].c !== 0 ||
            wq[base].b !== 22'h100002 || wq[base].t !== 22'h0) begin
            miscompares++;
            $display("FAIL restart_first: got bad first window expected (0,0) bottom 100002");
        end
        vectors++;
        if (base + 5 >= wq.size() || wq[base+5].t !== 22'h000001 ||
            wq[base+5].r !== 2 || wq[base+5].c !== 1) begin
            miscompares++;
            $display("FAIL restart_last: got bad last window expected (2,1) top 000001");
        end
    endtask

    initial begin
        test_reset();
        test_halo_count();
        test_timing();
        test_edges();
        test_backpressure();
        test_abuse();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
